// File: rtl/float_to_fixed_pipe.sv
// Three-stage IEEE-754 single-precision to signed fixed-point converter feeding the CORDIC pipe.
// One global enable stalls every stage together, so downstream backpressure never drops or duplicates items.
module float_to_fixed_pipe #(
    parameter int OUT_W  = 22,
    parameter int FRAC_W = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      float_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] fixed_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_ovf,
    output logic             out_nan
);
    localparam int               WIDE      = 24 + OUT_W;
    localparam logic [OUT_W-1:0] POS_MAX   = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] NEG_MIN   = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [WIDE-1:0]  EXACT_MAG = WIDE'(1) << (OUT_W - 1);

    logic en;

    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    logic        s1_valid;
    logic        s1_sign;
    logic        s1_zero;
    logic        s1_inf;
    logic        s1_nan;
    logic [7:0]  s1_exp;
    logic [23:0] s1_man;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_zero  <= 1'b0;
            s1_inf   <= 1'b0;
            s1_nan   <= 1'b0;
            s1_exp   <= '0;
            s1_man   <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_sign  <= float_in[31];
            s1_zero  <= (float_in[30:23] == 8'h00);
            s1_inf   <= (float_in[30:23] == 8'hFF) && (float_in[22:0] == 23'd0);
            s1_nan   <= (float_in[30:23] == 8'hFF) && (float_in[22:0] != 23'd0);
            s1_exp   <= float_in[30:23];
            s1_man   <= {1'b1, float_in[22:0]};
        end
    end

    // Alignment: the magnitude lands in a wide vector so overflow and the exact -2^(OUT_W-1)
    // case can be detected the same way for both shift directions.
    logic signed [11:0] sh;
    logic [11:0]        rsh;
    logic [23:0]        rshifted;
    logic [WIDE-1:0]    mag_wide;
    logic [OUT_W-1:0]   align_mag;
    logic               align_ovf;
    logic               align_exact;

    always_comb begin
        sh          = 12'(s1_exp) + 12'(FRAC_W) - 12'd150;
        rsh         = -sh;
        rshifted    = '0;
        mag_wide    = '0;
        align_ovf   = 1'b0;
        align_exact = 1'b0;
        if (!sh[11]) begin
            if (sh[10:0] >= 11'(OUT_W - 1)) begin
                align_ovf = 1'b1;
            end else begin
                mag_wide = WIDE'(s1_man) << sh[10:0];
            end
        end else if (rsh < 12'd24) begin
            rshifted = s1_man >> rsh;
            mag_wide = WIDE'(rshifted);
        end
        if (|mag_wide[WIDE-1:OUT_W-1]) begin
            align_ovf = 1'b1;
        end
        align_exact = (mag_wide == EXACT_MAG);
        align_mag   = mag_wide[OUT_W-1:0];
    end

    logic             s2_valid;
    logic             s2_sign;
    logic             s2_zero;
    logic             s2_inf;
    logic             s2_nan;
    logic             s2_ovf;
    logic             s2_exact;
    logic [OUT_W-1:0] s2_mag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_zero  <= 1'b0;
            s2_inf   <= 1'b0;
            s2_nan   <= 1'b0;
            s2_ovf   <= 1'b0;
            s2_exact <= 1'b0;
            s2_mag   <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_zero  <= s1_zero;
            s2_inf   <= s1_inf;
            s2_nan   <= s1_nan;
            s2_ovf   <= align_ovf;
            s2_exact <= align_exact;
            s2_mag   <= align_mag;
        end
    end

    // A magnitude of exactly 2^(OUT_W-1) is representable only as a negative result.
    logic [OUT_W-1:0] sat_val;
    logic             sat_ovf;
    logic             sat_nan;

    always_comb begin
        sat_val = '0;
        sat_ovf = 1'b0;
        sat_nan = 1'b0;
        if (s2_nan) begin
            sat_nan = 1'b1;
        end else if (s2_inf) begin
            sat_ovf = 1'b1;
            sat_val = s2_sign ? NEG_MIN : POS_MAX;
        end else if (s2_zero) begin
            sat_val = '0;
        end else if (!s2_sign) begin
            if (s2_ovf) begin
                sat_ovf = 1'b1;
                sat_val = POS_MAX;
            end else begin
                sat_val = s2_mag;
            end
        end else begin
            if (s2_ovf && !s2_exact) begin
                sat_ovf = 1'b1;
                sat_val = NEG_MIN;
            end else begin
                sat_val = -s2_mag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            fixed_out <= '0;
            out_ovf   <= 1'b0;
            out_nan   <= 1'b0;
        end else if (en) begin
            out_valid <= s2_valid;
            fixed_out <= sat_val;
            out_ovf   <= sat_ovf;
            out_nan   <= sat_nan;
        end
    end

endmodule

// File: tb/tb_float_to_fixed_pipe.sv
// Scoreboard bench for float_to_fixed_pipe: a real-arithmetic reference model predicts every
// result at accept time, and an independent monitor pops and compares on each output handshake.
module tb_float_to_fixed_pipe;
    localparam int OUT_W  = 22;
    localparam int FRAC_W = 19;

    logic             clk;
    logic             rst_n;
    logic [31:0]      float_in;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] fixed_out;
    logic             out_valid;
    logic             out_ready;
    logic             out_ovf;
    logic             out_nan;

    typedef struct packed {
        logic [OUT_W-1:0] val;
        logic             ovf;
        logic             nan;
    } result_t;

    result_t          exp_q[$];
    int               checks = 0;
    int               errors = 0;
    int               ready_mode = 0;
    int               cyc = 0;
    int               bp_start = 0;
    logic             stalled;
    logic [OUT_W-1:0] stall_val;
    logic             stall_ovf;
    logic             stall_nan;

    logic [31:0]      dir_in  [6] = '{32'h40a00000, 32'hc0800000, 32'hc1000000,
                                      32'hff800000, 32'h7fc00000, 32'h80000000};
    logic [OUT_W-1:0] dir_val [6] = '{22'h1FFFFF, 22'h200000, 22'h200000,
                                      22'h200000, 22'h000000, 22'h000000};
    logic             dir_ovf [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic             dir_nan [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0]      b2b_in  [3] = '{32'hbf000000, 32'h40490fdb, 32'h00000001};
    logic [OUT_W-1:0] b2b_val [3] = '{22'h3C0000, 22'h1921FB, 22'h000000};

    float_to_fixed_pipe #(.OUT_W(OUT_W), .FRAC_W(FRAC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .float_in  (float_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fixed_out (fixed_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ovf   (out_ovf),
        .out_nan   (out_nan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Value = 1.frac * 2^(e-127), scaled by 2^FRAC_W, truncated toward zero, then saturated.
    function automatic result_t reference_model(input logic [31:0] f);
        result_t          r;
        int               e;
        int               frac;
        real              mag;
        real              lim;
        longint           v;
        logic [OUT_W-1:0] pos_max;
        logic [OUT_W-1:0] neg_min;
        r       = '0;
        e       = int'(f[30:23]);
        frac    = int'(f[22:0]);
        lim     = 2.0 ** (OUT_W - 1);
        neg_min = OUT_W'(longint'(1) << (OUT_W - 1));
        pos_max = neg_min - 1'b1;
        if (e == 255) begin
            if (frac != 0) begin
                r.nan = 1'b1;
            end else begin
                r.ovf = 1'b1;
                r.val = f[31] ? neg_min : pos_max;
            end
        end else if (e != 0) begin
            mag = $floor(real'(frac + (1 << 23)) * (2.0 ** (e - 150 + FRAC_W)));
            if (!f[31] && mag >= lim) begin
                r.ovf = 1'b1;
                r.val = pos_max;
            end else if (f[31] && mag > lim) begin
                r.ovf = 1'b1;
                r.val = neg_min;
            end else begin
                v = longint'(mag);
                if (f[31]) v = -v;
                r.val = OUT_W'(v);
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_float(input bit in_range);
        logic [31:0] f;
        int          k;
        f = $urandom;
        if (in_range) begin
            f[30:23] = 8'($urandom_range(105, 128));
        end else begin
            k = $urandom_range(0, 9);
            if (k < 5) begin
                f[30:23] = 8'($urandom_range(100, 135));
            end else if (k == 5) begin
                f[30:23] = 8'hFF;
                if ($urandom_range(0, 1) == 0) f[22:0] = '0;
            end else if (k == 6) begin
                f[30:23] = 8'h00;
            end
        end
        return f;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        case (ready_mode)
            1:       out_ready = ($urandom_range(0, 3) != 0);
            2:       out_ready = !((cyc - bp_start) >= 4 && (cyc - bp_start) <= 8);
            default: out_ready = 1'b1;
        endcase
    endtask

    // Presents one item (or one idle cycle) and returns 1ns after the edge that accepted it.
    task automatic applyStimulus(input logic [31:0] f, input logic valid);
        int waited;
        waited   = 0;
        float_in = f;
        in_valid = valid;
        if (!valid) begin
            tick();
        end else begin
            forever begin
                @(negedge clk);
                if (in_ready) begin
                    tick();
                    break;
                end
                tick();
                waited++;
                if (waited > 200) begin
                    checkOutput("accept_timeout", 64'(waited), 64'd0);
                    break;
                end
            end
        end
    endtask

    task automatic drain();
        int n;
        n          = 0;
        in_valid   = 1'b0;
        ready_mode = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        repeat (4) tick();
        checkOutput("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) exp_q.push_back(reference_model(float_in));
    end

    always @(negedge rst_n) exp_q.delete();

    initial begin
        result_t e;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    checkOutput("stall_valid", 64'(out_valid), 64'd1);
                    checkOutput("stall_data", 64'({fixed_out, out_ovf, out_nan}),
                                64'({stall_val, stall_ovf, stall_nan}));
                end
                if (out_valid && !out_ready) checkOutput("in_ready_stall", 64'(in_ready), 64'd0);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_output: got 0x%0h, expected no output", fixed_out);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("fixed_out", 64'(fixed_out), 64'(e.val));
                        checkOutput("out_ovf", 64'(out_ovf), 64'(e.ovf));
                        checkOutput("out_nan", 64'(out_nan), 64'(e.nan));
                    end
                end
                stalled   = out_valid && !out_ready;
                stall_val = fixed_out;
                stall_ovf = out_ovf;
                stall_nan = out_nan;
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        float_in  = '0;
        out_ready = 1'b1;
        #1;
        checkOutput("reset_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_data", 64'({fixed_out, out_ovf, out_nan}), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        $display("[TB] single 1.0 latency");
        applyStimulus(32'h3f800000, 1'b1);
        in_valid = 1'b0;
        checkOutput("lat_edge1", 64'(out_valid), 64'd0);
        tick();
        checkOutput("lat_edge2", 64'(out_valid), 64'd0);
        tick();
        checkOutput("lat_edge3_valid", 64'(out_valid), 64'd1);
        checkOutput("lat_edge3_data", 64'({fixed_out, out_ovf, out_nan}), 64'({22'h080000, 2'b00}));
        tick();
        checkOutput("lat_after", 64'(out_valid), 64'd0);

        $display("[TB] back-to-back");
        for (int i = 0; i < 3; i++) applyStimulus(b2b_in[i], 1'b1);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("b2b_valid", 64'(out_valid), 64'd1);
            checkOutput("b2b_data", 64'({fixed_out, out_ovf, out_nan}), 64'({b2b_val[i], 2'b00}));
            tick();
        end
        checkOutput("b2b_end", 64'(out_valid), 64'd0);

        $display("[TB] boundaries");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(dir_in[i], 1'b1);
            in_valid = 1'b0;
            repeat (2) tick();
            checkOutput("bound_valid", 64'(out_valid), 64'd1);
            checkOutput("bound_data", 64'({fixed_out, out_ovf, out_nan}),
                        64'({dir_val[i], dir_ovf[i], dir_nan[i]}));
            tick();
        end

        $display("[TB] backpressure");
        ready_mode = 2;
        bp_start   = cyc;
        for (int i = 0; i < 10; i++) applyStimulus(rand_float(1'b1), 1'b1);
        drain();

        $display("[TB] reset mid-stream");
        applyStimulus(32'h3f800000, 1'b1);
        applyStimulus(32'h40490fdb, 1'b1);
        applyStimulus(32'hbf000000, 1'b1);
        in_valid = 1'b0;
        checkOutput("pre_reset_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_valid", 64'(out_valid), 64'd0);
        checkOutput("async_reset_data", 64'({fixed_out, out_ovf, out_nan}), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        checkOutput("post_reset_idle", 64'(out_valid), 64'd0);
        applyStimulus(32'h3f800000, 1'b1);
        drain();

        $display("[TB] random regression");
        ready_mode = 1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) != 0) applyStimulus(rand_float(1'b0), 1'b1);
            else applyStimulus(32'h0, 1'b0);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/float_to_fixed_pipe.md
Name: float_to_fixed_pipe

Overview:
Pipelined IEEE-754 single-precision to signed fixed-point converter. It sits directly upstream of the multi-stage CORDIC pipeline and turns the 32-bit float operand into the two's-complement fixed-point word the CORDIC datapath consumes. The block has 3 register stages and valid/ready flow control, so the CORDIC front end can stall it.

Parameters:
OUT_W, 22, total width of the fixed-point output in bits (sign included).
FRAC_W, 19, fractional bits. Default format is Q3.19, range [-4.0, 4.0).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
float_in  input  32  IEEE-754 single-precision operand
in_valid  input  1  float_in is valid this cycle
in_ready  output  1  block accepts float_in this cycle
fixed_out  output  OUT_W  signed two's-complement result
out_valid  output  1  fixed_out and flags are valid
out_ready  input  1  downstream accepts fixed_out this cycle
out_ovf  output  1  result saturated (overflow, or ±Inf input)
out_nan  output  1  input was NaN; fixed_out forced to 0

Behaviour:
- Reset (rst_n low, asynchronous): every stage valid bit is cleared. fixed_out=0, out_valid=0, out_ovf=0, out_nan=0. All internal data registers are 0. Reset takes effect immediately mid-stream; in-flight items are discarded. The first accept is possible on the first rising edge after rst_n deasserts.
- Flow control: one global enable, en = ~out_valid | out_ready. in_ready = en, combinationally.
  - When en=1, all stages advance. When en=0, all stages hold data and valid bits unchanged.
  - A transfer occurs on each edge with in_valid & in_ready. There is no combinational path from in_valid to out_valid.
- Latency: exactly 3 clk edges from accept to out_valid, when out_ready is held high. Throughput is 1 item per cycle with no bubbles.
- S1 (unpack/classify) splits the input into:
  - sign s.
  - exponent e (8b).
  - mantissa m = {1, frac} (24b).
  - Classes: zero/denormal (e==0) is treated as zero; Inf (e==255, frac==0); NaN (e==255, frac!=0).
- S2 (align):
  - Shift amount sh = e - 150 + FRAC_W, computed signed and at least 10b wide.
  - sh >= 0: magnitude = m << sh. Overflow is flagged if any set bit lands at or above bit OUT_W-1. Also compute whether the magnitude equals exactly 2^(OUT_W-1), which is legal only for a negative result.
  - sh < 0: magnitude = m >> -sh, truncated toward zero. If sh <= -24, magnitude = 0.
- S3 (sign/saturate):
  - Positive, in range: fixed_out = magnitude.
  - Negative: fixed_out = -magnitude.
  - Positive overflow or +Inf: fixed_out = 2^(OUT_W-1)-1, out_ovf=1.
  - Negative magnitude > 2^(OUT_W-1), or -Inf: fixed_out = -2^(OUT_W-1), out_ovf=1.
  - NaN: fixed_out=0, out_nan=1, out_ovf=0.
  - Zero/denormal: fixed_out=0 for either sign; no flags.
- Flags travel with their data word and are valid only when out_valid=1.
- Simultaneous events:
  - Accept plus output handshake in the same cycle is normal streaming.
  - When out_valid=0, the pipe advances even if out_ready=0, so bubbles fill.
  - in_valid=0 with en=1 shifts a bubble in.
- Ordering: outputs leave in input order. No item is dropped or duplicated under any out_ready pattern.

Test Plan:
- Reset, then a single 0x3f800000 (1.0) with out_ready=1 -> out_valid on the 3rd edge after accept, fixed_out=0x080000, flags 0, then out_valid=0.
- Back-to-back 0xbf000000 (-0.5), 0x40490fdb (pi), 0x00000001 (denormal) -> 0x3C0000, 0x1921FB, 0x000000 on 3 consecutive cycles, no flags.
- Boundaries: 0x40a00000 (5.0) -> 0x1FFFFF, ovf=1. 0xc0800000 (-4.0) -> 0x200000, ovf=0. 0xc1000000 (-8.0) -> 0x200000, ovf=1. 0xff800000 (-Inf) -> 0x200000, ovf=1. 0x7fc00000 (NaN) -> 0, nan=1. 0x80000000 (-0) -> 0.
- Backpressure: stream 10 random in-range floats with in_valid=1, drop out_ready for cycles 4-8 -> in_ready=0 while out_valid & ~out_ready, out_valid and fixed_out stable during the stall, all 10 results match a reference model in order.
- Reset mid-stream: assert rst_n=0 asynchronously (between edges) with 3 items in flight -> out_valid, fixed_out and flags go to 0 immediately. After release, new input 0x3f800000 yields only 0x080000; no stale outputs appear.
- Random regression: 10k random 32-bit patterns with random in_valid/out_ready -> every output matches a truncating reference model, including both flags.
